// File: rtl/sort_chain_ctrl.sv
// Sequencer for the SR_N sorting chain: fills the chain from an input
// stream, then drains the sorted words to the downstream stream.
//
// Ports:
//   clk, reset (async, active-low), abort (sync frame discard)
//   in_valid/in_data/in_last/in_ready : sample input stream
//   sr_new/sr_ins_en/sr_load/sr_clr   : chain controls, sr_tail : chain tail
//   out_valid/out_data/out_last/out_ready : drained word stream
//   occupancy : samples held, frame_cnt : frames fully drained
module sort_chain_ctrl #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 10,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] sr_new,
  output logic              sr_ins_en,
  output logic [1:0]        sr_load,
  output logic              sr_clr,
  input  logic [DATA_W-1:0] sr_tail,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  occupancy,
  output logic [15:0]       frame_cnt
);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic [15:0]       frame_q, frame_d;
  logic              in_hs;
  logic              out_hs;
  logic              full_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CLEAR;
      occ_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      frame_q <= frame_d;
    end
  end

  assign sr_new    = in_data;
  assign out_data  = sr_tail;
  assign occupancy = occ_q;
  assign frame_cnt = frame_q;

  always_comb begin
    state_d   = state_q;
    occ_d     = occ_q;
    frame_d   = frame_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    sr_ins_en = 1'b0;
    sr_load   = 2'b00;
    sr_clr    = 1'b0;
    in_hs     = 1'b0;
    out_hs    = 1'b0;
    full_hit  = 1'b0;

    unique case (state_q)
      CLEAR: begin
        sr_clr  = 1'b1;
        occ_d   = '0;
        state_d = FILL;
      end
      FILL: begin
        in_ready  = !abort;
        sr_ins_en = in_valid && !abort;
        in_hs     = in_valid && !abort;
        if (in_hs) begin
          occ_d    = occ_q + 1'b1;
          // in_last and a full chain on the same sample close once
          full_hit = (occ_q == CNT_W'(DEPTH - 1));
          if (in_last || full_hit) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        out_valid = !abort;
        out_last  = !abort && (occ_q == CNT_W'(1));
        out_hs    = out_valid && out_ready;
        if (out_hs) begin
          sr_load = 2'b11;
          occ_d   = occ_q - 1'b1;
          if (out_last) begin
            frame_d = frame_q + 16'd1;
            state_d = CLEAR;
          end
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase

    // abort discards the frame; the CLEAR cycle wipes the chain
    if (abort) begin
      state_d = CLEAR;
      occ_d   = '0;
    end
  end

endmodule

// File: tb/tb_sort_chain_ctrl.sv
// Bench for sort_chain_ctrl with a behavioural sorting chain on sr_tail
// and a scoreboard of sorted frames checked on every drain handshake.
module tb_sort_chain_ctrl;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 10;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              reset;
  logic              abort;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic [DATA_W-1:0] sr_new;
  logic              sr_ins_en;
  logic [1:0]        sr_load;
  logic              sr_clr;
  logic [DATA_W-1:0] sr_tail;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic [CNT_W-1:0]  occupancy;
  logic [15:0]       frame_cnt;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  int exp_occ;
  int base;

  logic [DATA_W-1:0] cur[$];
  logic [DATA_W-1:0] exp_d[$];
  logic              exp_l[$];
  logic [DATA_W-1:0] chain[$];

  logic              lat_clr;
  logic              lat_ins;
  logic [1:0]        lat_load;
  logic [DATA_W-1:0] lat_new;

  sort_chain_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .sr_new(sr_new), .sr_ins_en(sr_ins_en),
    .sr_load(sr_load), .sr_clr(sr_clr), .sr_tail(sr_tail),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .occupancy(occupancy), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // scoreboard and chain-control sampling, away from the active edge
  always @(negedge clk) begin
    lat_clr  = sr_clr;
    lat_ins  = sr_ins_en;
    lat_load = sr_load;
    lat_new  = sr_new;
    if (!reset || abort) begin
      cur.delete();
      exp_d.delete();
      exp_l.delete();
    end else begin
      if (in_valid && in_ready) begin
        logic [DATA_W-1:0] tmp[$];
        cur.push_back(in_data);
        if (in_last || cur.size() == DEPTH) begin
          tmp = cur;
          tmp.sort();
          foreach (tmp[i]) begin
            exp_d.push_back(tmp[i]);
            exp_l.push_back(i == tmp.size() - 1);
          end
          cur.delete();
        end
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_d.size() == 0) begin
          chk("unexpected_word", 32'(1), 32'(0));
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_d.pop_front()));
          chk("out_last_sb", 32'(out_last), 32'(exp_l.pop_front()));
        end
      end
    end
  end

  // behavioural sorting chain: tail holds the smallest value
  always @(posedge clk) begin
    if (lat_clr) begin
      chain.delete();
    end else if (lat_load == 2'b11) begin
      if (chain.size() != 0) void'(chain.pop_front());
    end else if (lat_ins) begin
      int p;
      p = 0;
      while (p < chain.size() && chain[p] <= lat_new) p++;
      chain.insert(p, lat_new);
    end
    sr_tail = (chain.size() != 0) ? chain[0] : '0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    chk("fill_in_ready", 32'(in_ready), 32'(1));
    chk("fill_ins_en", 32'(sr_ins_en), 32'(1));
    chk("fill_load", 32'(sr_load), 32'(0));
    chk("fill_sr_new", 32'(sr_new), 32'(d));
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic word();
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_valid", 32'(out_valid), 32'(1));
    chk("drain_load", 32'(sr_load), 32'(3));
    chk("drain_last", 32'(out_last), 32'(exp_occ == 1));
    chk("drain_occ", 32'(occupancy), 32'(exp_occ));
    tick();
    exp_occ--;
    out_ready = 1'b0;
  endtask

  task automatic stall();
    out_ready = 1'b0;
    @(negedge clk);
    chk("stall_valid", 32'(out_valid), 32'(1));
    chk("stall_load", 32'(sr_load), 32'(0));
    chk("stall_ins_en", 32'(sr_ins_en), 32'(0));
    chk("stall_data", 32'(out_data), 32'(exp_d[0]));
    chk("stall_occ", 32'(occupancy), 32'(exp_occ));
    tick();
  endtask

  task automatic after_drain(input int fc, input int words);
    @(negedge clk);
    chk("clear_sr_clr", 32'(sr_clr), 32'(1));
    chk("clear_in_ready", 32'(in_ready), 32'(0));
    chk("clear_out_valid", 32'(out_valid), 32'(0));
    chk("frame_cnt", 32'(frame_cnt), 32'(fc));
    chk("sb_empty", 32'(exp_d.size()), 32'(0));
    chk("word_count", 32'(n_out - base), 32'(words));
    tick();
    @(negedge clk);
    chk("refill_in_ready", 32'(in_ready), 32'(1));
    chk("refill_sr_clr", 32'(sr_clr), 32'(0));
    tick();
  endtask

  task automatic closed(input int occ);
    @(negedge clk);
    chk("closed_in_ready", 32'(in_ready), 32'(0));
    chk("closed_valid", 32'(out_valid), 32'(1));
    chk("closed_occ", 32'(occupancy), 32'(occ));
    exp_occ = occ;
    base    = n_out;
    tick();
  endtask

  initial begin
    reset     = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    sr_tail   = '0;
    lat_clr   = 1'b1;
    lat_ins   = 1'b0;
    lat_load  = 2'b00;
    lat_new   = '0;

    // reset values
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_last", 32'(out_last), 32'(0));
    chk("rst_ins_en", 32'(sr_ins_en), 32'(0));
    chk("rst_load", 32'(sr_load), 32'(0));
    chk("rst_sr_clr", 32'(sr_clr), 32'(1));
    chk("rst_occ", 32'(occupancy), 32'(0));
    chk("rst_frame_cnt", 32'(frame_cnt), 32'(0));
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("first_clear", 32'(sr_clr), 32'(1));
    chk("first_clear_rdy", 32'(in_ready), 32'(0));
    tick();
    @(negedge clk);
    chk("fill_idle_clr", 32'(sr_clr), 32'(0));
    chk("fill_idle_rdy", 32'(in_ready), 32'(1));
    chk("fill_idle_ins", 32'(sr_ins_en), 32'(0));
    tick();

    // frame 5,9,1,7
    send(10'd5, 1'b0);
    send(10'd9, 1'b0);
    send(10'd1, 1'b0);
    send(10'd7, 1'b1);
    closed(4);
    for (int i = 0; i < 4; i++) word();
    after_drain(1, 4);

    // 16 samples, none flagged last; drain with out_ready 1,0,0,1
    for (int i = 0; i < DEPTH; i++)
      send(DATA_W'($urandom_range(0, 1023)), 1'b0);
    closed(16);
    word();
    stall();
    stall();
    word();
    for (int i = 0; i < DEPTH - 2; i++) word();
    after_drain(2, 16);

    // in_last on the 16th sample: a single close
    for (int i = 0; i < DEPTH; i++)
      send(DATA_W'($urandom_range(0, 1023)), i == DEPTH - 1);
    closed(16);
    for (int i = 0; i < DEPTH; i++) word();
    after_drain(3, 16);

    // abort mid-fill at occupancy 3, with a competing valid sample
    send(10'd100, 1'b0);
    send(10'd200, 1'b0);
    send(10'd300, 1'b0);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 10'd400;
    @(negedge clk);
    chk("abort_occ_before", 32'(occupancy), 32'(3));
    chk("abort_in_ready", 32'(in_ready), 32'(0));
    chk("abort_ins_en", 32'(sr_ins_en), 32'(0));
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_sr_clr", 32'(sr_clr), 32'(1));
    chk("abort_occ", 32'(occupancy), 32'(0));
    chk("abort_frame_cnt", 32'(frame_cnt), 32'(3));
    tick();
    @(negedge clk);
    chk("abort_refill", 32'(in_ready), 32'(1));
    chk("abort_clr_once", 32'(sr_clr), 32'(0));
    tick();

    // reset during drain with occupancy 6
    for (int i = 0; i < 6; i++)
      send(DATA_W'(50 - 3 * i), i == 5);
    closed(6);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_clr", 32'(sr_clr), 32'(1));
    chk("mid_rst_occ", 32'(occupancy), 32'(0));
    chk("mid_rst_fc", 32'(frame_cnt), 32'(0));
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_clear", 32'(sr_clr), 32'(1));
    chk("post_rst_rdy", 32'(in_ready), 32'(0));
    tick();
    @(negedge clk);
    chk("post_rst_fill", 32'(in_ready), 32'(1));
    tick();

    // single-sample frame
    send(10'd42, 1'b1);
    base      = n_out;
    out_ready = 1'b1;
    @(negedge clk);
    chk("single_valid", 32'(out_valid), 32'(1));
    chk("single_last", 32'(out_last), 32'(1));
    chk("single_data", 32'(out_data), 32'(42));
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("single_bubble", 32'(in_ready), 32'(0));
    tick();
    @(negedge clk);
    chk("single_refill", 32'(in_ready), 32'(1));
    chk("single_fc", 32'(frame_cnt), 32'(1));
    chk("single_words", 32'(n_out - base), 32'(1));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
